count_compare_pwm: RTL
======================

Name: count_compare_pwm

Overview:
- Downstream consumer of the free-running 16-bit counter's `count` output.
- Detects counter wrap-around and compares the count against a programmable threshold.
- Produces a PWM level, a one-cycle match pulse and a one-cycle wrap pulse.
- The threshold is double-buffered: new values take effect only at a wrap, so PWM periods are never torn.

Parameters:
- WIDTH, 16, counter/compare width.
- WRAP_CNT_W, 8, width of the saturating wrap counter.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; synchronous, active-high.
- i_en  in  1  block enable.
- i_count  in  WIDTH  counter value from upstream.
- i_cmp_valid  in  1  compare-load request.
- i_cmp  in  WIDTH  compare value; sampled when i_cmp_valid & o_cmp_ready.
- o_cmp_ready  out  1  shadow register free.
- o_pwm  out  1  PWM level.
- o_match  out  1  one-cycle pulse on count == active compare.
- o_wrap  out  1  one-cycle pulse on detected wrap.
- o_wrap_cnt  out  WRAP_CNT_W  wraps seen in RUN, saturating.
- o_state  out  2  FSM state, for debug.

Behaviour:
- Reset (i_rst high at a rising edge) sets all of the following:
  - state IDLE;
  - count_q, count_prev, cmp_active, cmp_shadow = 0;
  - pending = 0, prev_valid = 0;
  - o_pwm, o_match, o_wrap = 0; o_wrap_cnt = 0; o_state = 0.
  - o_cmp_ready = ~pending, so it reads 1 after reset.
- Reset mid-operation discards any pending compare value.
- Pipeline:
  - Stage 1 registers i_count into count_q and the old count_q into count_prev; prev_valid is set after the first sample.
  - Stage 2 registers all outputs from count_q.
  - o_pwm, o_match and o_wrap reflect an i_count value sampled two edges earlier.
- Wrap event: prev_valid & (count_q < count_prev), unsigned. A held (equal) count is not a wrap.
- FSM, encoded IDLE=0, SYNC=1, RUN=2:
  - IDLE → SYNC when i_en = 1.
  - SYNC → RUN on the first wrap event.
  - Any state → IDLE when i_en = 0, effective on the next edge.
  - In IDLE and SYNC: o_pwm = 0, o_match = 0, o_wrap_cnt holds.
  - o_wrap pulses in SYNC and RUN.
- Compare handshake:
  - A transfer occurs when i_cmp_valid & o_cmp_ready at an edge.
  - In IDLE, the value loads directly into cmp_active and pending stays 0.
  - Otherwise, the value loads into cmp_shadow and pending is set; o_cmp_ready drops on the next cycle.
  - At a wrap event with pending = 1 (including SYNC → RUN): cmp_active ← cmp_shadow and pending clears.
  - Handshake and wrap on the same edge: the wrap applies the old pending state, and the new value becomes pending. Since ready = 1 implies no pending, the new value is applied at the following wrap.
  - i_cmp_valid is ignored while o_cmp_ready = 0; the requester holds it.
- RUN outputs:
  - o_pwm = (count_q < cmp_active). cmp_active = 0 gives constant 0.
  - o_match pulses when count_q == cmp_active and count_q != count_prev, so a stalled counter produces no repeat pulses.
  - o_wrap_cnt increments on each wrap and saturates at all-ones.
- i_en toggling preserves cmp_active, cmp_shadow and pending. o_wrap_cnt is cleared only by reset.

Optional Feature:
- Macro: CCP_CAPTURE_EN.
- When defined, the following ports are added:
  - i_capture (1, pre-synchronised);
  - o_capture (WIDTH);
  - o_capture_valid (1).
- On an i_capture rising edge, detected against its registered copy while in RUN:
  - o_capture ← count_q;
  - o_capture_valid pulses for one cycle.
- Reset values: o_capture = 0, o_capture_valid = 0.
- When undefined, these ports and their logic are absent and behaviour is otherwise identical.

Decomposition:
- Package count_cmp_pkg holds:
  - state encodings ST_IDLE, ST_SYNC, ST_RUN;
  - the default WIDTH (16);
  - the default WRAP_CNT_W (8).
- One sub-module, count_wrap_detect, owns count_q, count_prev and prev_valid, and emits a wrap strobe.

Test Plan:
1. Reset check: reset held 3 cycles, i_count = 0x1234 → all outputs 0, o_cmp_ready = 1, o_state = 0.
2. IDLE load and PWM duty:
   - Load cmp = 0x0008 in IDLE, enable, drive count 0xFFF0..0xFFFF,0x0000..0x0010.
   - Wrap is detected at 0xFFFF → 0x0000; SYNC → RUN.
   - o_pwm is high for counts 0x0000–0x0007.
   - o_match pulses once at 0x0008, with two-cycle latency.
3. Double-buffered load:
   - In RUN, load 0x0004 mid-period → o_cmp_ready = 0.
   - The old threshold 0x0008 holds until the next wrap, after which PWM high covers 0x0000–0x0003 and ready returns to 1.
4. Handshake on the wrap cycle: transfer lands on the same edge as a wrap → the value is not applied at that wrap; it is applied at the next one.
5. Counter stall and wrap saturation:
   - Hold i_count = 0x0008 for 5 cycles → a single o_match pulse and no o_wrap.
   - Force 300 wraps → o_wrap_cnt = 0xFF.
6. Disable and optional capture:
   - Drop i_en mid-period → o_pwm = 0 and o_state = IDLE next cycle.
   - With CCP_CAPTURE_EN, pulse i_capture at count 0x0123 in RUN → o_capture = 0x0123 and o_capture_valid high for 1 cycle.

Source files
------------

// File: rtl/count_cmp_pkg.sv
// Shared definitions for the count/compare PWM block: FSM encodings and
// default widths.
package count_cmp_pkg;

    localparam int DEF_WIDTH      = 16;
    localparam int DEF_WRAP_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_RUN  = 2'd2
    } ccp_state_e;

endpackage : count_cmp_pkg

// File: rtl/count_wrap_detect.sv
// Stage 1 of count_compare_pwm: samples the upstream counter and flags a
// wrap whenever the new sample is strictly below the previous one.
module count_wrap_detect
    import count_cmp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_count,
    output logic [WIDTH-1:0] o_count_q,
    output logic [WIDTH-1:0] o_count_prev,
    output logic             o_wrap
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_prev_q;
    logic             prev_valid_q;

    // Sample the counter every cycle and keep one sample of history.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q      <= '0;
            count_prev_q <= '0;
            prev_valid_q <= 1'b0;
        end else begin
            count_q      <= i_count;
            count_prev_q <= count_q;
            prev_valid_q <= 1'b1;
        end
    end

    // A held (equal) count is not a wrap; only a strict decrease is.
    assign o_wrap       = prev_valid_q & (count_q < count_prev_q);
    assign o_count_q    = count_q;
    assign o_count_prev = count_prev_q;

endmodule : count_wrap_detect

// File: rtl/count_compare_pwm.sv
// Count/compare PWM: follows an upstream free-running counter, detects wraps,
// and produces PWM, match and wrap pulses against a double-buffered threshold.
// Optional capture port set is enabled with the CCP_CAPTURE_EN macro.
//
// Compare handshake: a value transfers on any rising edge where
// i_cmp_valid & o_cmp_ready; o_cmp_ready is simply ~pending, and the
// requester must hold i_cmp_valid/i_cmp while ready is low.
module count_compare_pwm
    import count_cmp_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int WRAP_CNT_W = DEF_WRAP_CNT_W
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic [WIDTH-1:0]      i_count,
    input  logic                  i_cmp_valid,
    input  logic [WIDTH-1:0]      i_cmp,
    output logic                  o_cmp_ready,
    output logic                  o_pwm,
    output logic                  o_match,
    output logic                  o_wrap,
    output logic [WRAP_CNT_W-1:0] o_wrap_cnt,
`ifdef CCP_CAPTURE_EN
    input  logic                  i_capture,
    output logic [WIDTH-1:0]      o_capture,
    output logic                  o_capture_valid,
`endif
    output logic [1:0]            o_state
);

    ccp_state_e            state_q, state_d;
    logic [WIDTH-1:0]      count_q;
    logic [WIDTH-1:0]      count_prev;
    logic                  wrap;

    logic [WIDTH-1:0]      cmp_active_q, cmp_active_d;
    logic [WIDTH-1:0]      cmp_shadow_q, cmp_shadow_d;
    logic                  pending_q, pending_d;
    logic                  pwm_q, pwm_d;
    logic                  match_q, match_d;
    logic                  wrap_q, wrap_d;
    logic [WRAP_CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;

    logic                  running;
    logic                  apply_shadow;
    logic                  xfer;
    logic [WIDTH-1:0]      cmp_eff;

    count_wrap_detect #(
        .WIDTH (WIDTH)
    ) u_wrap_detect (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_count      (i_count),
        .o_count_q    (count_q),
        .o_count_prev (count_prev),
        .o_wrap       (wrap)
    );

    // Next-state logic: enable low always returns to IDLE on the next edge.
    always_comb begin
        state_d = state_q;
        if (!i_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_SYNC;
                ST_SYNC: if (wrap) state_d = ST_RUN;
                ST_RUN:  state_d = ST_RUN;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Threshold buffering and output decode. Outputs follow the state being
    // entered so the first count of the first RUN period is already valid,
    // and a shadow value promoted at this wrap is already used for it.
    always_comb begin
        running      = (state_q != ST_IDLE);
        apply_shadow = wrap & pending_q & running;
        xfer         = i_cmp_valid & ~pending_q;
        cmp_eff      = apply_shadow ? cmp_shadow_q : cmp_active_q;

        cmp_active_d = cmp_active_q;
        cmp_shadow_d = cmp_shadow_q;
        pending_d    = pending_q;
        wrap_cnt_d   = wrap_cnt_q;

        // xfer requires pending_q == 0, so it never collides with apply_shadow.
        if (apply_shadow) begin
            cmp_active_d = cmp_shadow_q;
            pending_d    = 1'b0;
        end
        if (xfer) begin
            if (state_q == ST_IDLE) begin
                cmp_active_d = i_cmp;
            end else begin
                cmp_shadow_d = i_cmp;
                pending_d    = 1'b1;
            end
        end

        pwm_d   = (state_d == ST_RUN) & (count_q < cmp_eff);
        match_d = (state_d == ST_RUN) & (count_q == cmp_eff) & (count_q != count_prev);
        wrap_d  = wrap & i_en & running;

        if (wrap & i_en & (state_q == ST_RUN) & (wrap_cnt_q != {WRAP_CNT_W{1'b1}})) begin
            wrap_cnt_d = wrap_cnt_q + {{(WRAP_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Stage 2 registers: FSM state, compare buffers and all outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            cmp_active_q <= '0;
            cmp_shadow_q <= '0;
            pending_q    <= 1'b0;
            pwm_q        <= 1'b0;
            match_q      <= 1'b0;
            wrap_q       <= 1'b0;
            wrap_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            cmp_active_q <= cmp_active_d;
            cmp_shadow_q <= cmp_shadow_d;
            pending_q    <= pending_d;
            pwm_q        <= pwm_d;
            match_q      <= match_d;
            wrap_q       <= wrap_d;
            wrap_cnt_q   <= wrap_cnt_d;
        end
    end

    assign o_cmp_ready = ~pending_q;
    assign o_pwm       = pwm_q;
    assign o_match     = match_q;
    assign o_wrap      = wrap_q;
    assign o_wrap_cnt  = wrap_cnt_q;
    assign o_state     = state_q;

`ifdef CCP_CAPTURE_EN
    logic             cap_prev_q;
    logic [WIDTH-1:0] capture_q;
    logic             capture_valid_q;

    // Latch the current count on a rising capture input while in RUN.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cap_prev_q      <= 1'b0;
            capture_q       <= '0;
            capture_valid_q <= 1'b0;
        end else begin
            cap_prev_q      <= i_capture;
            capture_valid_q <= 1'b0;
            if (i_capture & ~cap_prev_q & (state_q == ST_RUN)) begin
                capture_q       <= count_q;
                capture_valid_q <= 1'b1;
            end
        end
    end

    assign o_capture       = capture_q;
    assign o_capture_valid = capture_valid_q;
`else
    // Capture disabled: no capture ports or logic in this build.
`endif

endmodule : count_compare_pwm
